// File: rtl/complex_mag_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : complex_mag_stream_pkg
// Brief    : Shared widths and FSM state encoding for the de-scaling divider.
// Revision : 1.0 - initial release
// ============================================================================
package complex_mag_stream_pkg;

    localparam int DIV_NUM_W = 31;
    localparam int DIV_DEN_W = 6;
    localparam int DIV_Q_W   = 25;
    localparam int DIV_CNT_W = $clog2(DIV_NUM_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/complex_mag_stream_udiv_31ns_6ns_25_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : complex_mag_stream_udiv_31ns_6ns_25_seq_if
// Brief    : Operand and result handshake bundle for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
interface complex_mag_stream_udiv_31ns_6ns_25_seq_if
    import complex_mag_stream_pkg::*;
#(
    parameter int din0_WIDTH = DIV_NUM_W,
    parameter int din1_WIDTH = DIV_DEN_W,
    parameter int dout_WIDTH = DIV_Q_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  out_valid;
    logic                  out_ready;
    logic [dout_WIDTH-1:0] quot;
    logic [din1_WIDTH-1:0] rem;
    logic                  ovf;
    logic                  dz;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem, ovf, dz
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, ovf, dz
    );
endinterface
`default_nettype wire

// File: rtl/complex_mag_stream_udiv_step.sv
`default_nettype none
// ============================================================================
// Module   : complex_mag_stream_udiv_step
// Brief    : One restoring iteration: shift, compare, conditional subtract.
// Revision : 1.0 - initial release
// ============================================================================
module complex_mag_stream_udiv_step
    import complex_mag_stream_pkg::*;
#(
    parameter int NUM_W = DIV_NUM_W,
    parameter int DEN_W = DIV_DEN_W
) (
    input  logic [DEN_W:0]   prem,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [DEN_W:0]   prem_next,
    output logic [NUM_W-1:0] dividend_next
);
    logic [DEN_W+1:0] w_shift;
    logic             w_ge;
    logic [DEN_W:0]   w_sub;

    assign w_shift = {prem, dividend[NUM_W-1]};
    assign w_ge    = (w_shift >= {2'b00, divisor});
    // True difference is always below the divisor, so the dropped MSB is zero.
    assign w_sub   = w_shift[DEN_W:0] - {1'b0, divisor};

    assign prem_next     = w_ge ? w_sub : w_shift[DEN_W:0];
    assign dividend_next = {dividend[NUM_W-2:0], w_ge};
endmodule
`default_nettype wire

// File: rtl/complex_mag_stream_udiv_31ns_6ns_25_seq.sv
`default_nettype none
// ============================================================================
// Module   : complex_mag_stream_udiv_31ns_6ns_25_seq
// Brief    : Sequential restoring unsigned divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module complex_mag_stream_udiv_31ns_6ns_25_seq
    import complex_mag_stream_pkg::*;
#(
    parameter int din0_WIDTH = DIV_NUM_W,
    parameter int din1_WIDTH = DIV_DEN_W,
    parameter int dout_WIDTH = DIV_Q_W
) (
    input  logic ap_clk,
    input  logic ap_rst,
    complex_mag_stream_udiv_31ns_6ns_25_seq_if.slave bus
);
    localparam int CNT_W = $clog2(din0_WIDTH + 1);

    div_state_t r_state;
    div_state_t w_state_next;

    logic [din1_WIDTH:0]   r_prem;
    logic [din0_WIDTH-1:0] r_dividend;
    logic [din1_WIDTH-1:0] r_divisor;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [dout_WIDTH-1:0] r_quot;
    logic [din1_WIDTH-1:0] r_rem;
    logic                  r_ovf;
    logic                  r_dz;

    logic                  w_accept;
    logic [din1_WIDTH:0]   w_step_prem;
    logic [din0_WIDTH-1:0] w_step_dividend;
    logic                  w_dz;
    logic                  w_ovf;

    complex_mag_stream_udiv_step #(
        .NUM_W (din0_WIDTH),
        .DEN_W (din1_WIDTH)
    ) u_step (
        .prem          (r_prem),
        .dividend      (r_dividend),
        .divisor       (r_divisor),
        .prem_next     (w_step_prem),
        .dividend_next (w_step_dividend)
    );

    assign w_accept = bus.in_valid && r_in_ready && (r_state == IDLE);
    assign w_dz     = (r_divisor == '0);
    // After the last iteration the dividend register holds the full quotient.
    assign w_ovf    = |r_dividend[din0_WIDTH-1:dout_WIDTH];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (bus.din1 == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (r_out_valid && bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_prem      <= '0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            r_in_ready <= (w_state_next == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dividend <= bus.din0;
                        r_divisor  <= bus.din1;
                        r_prem     <= '0;
                        r_cnt      <= CNT_W'(din0_WIDTH);
                    end
                end
                CALC: begin
                    r_dividend <= w_step_dividend;
                    r_prem     <= w_step_prem;
                    r_cnt      <= r_cnt - CNT_W'(1);
                end
                DONE: begin
                    // First DONE cycle registers the result; it then holds under back-pressure.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_dz        <= w_dz;
                        if (w_dz) begin
                            r_quot <= '1;
                            r_rem  <= r_dividend[din1_WIDTH-1:0];
                            r_ovf  <= 1'b0;
                        end else begin
                            r_quot <= w_ovf ? '1 : r_dividend[dout_WIDTH-1:0];
                            r_rem  <= r_prem[din1_WIDTH-1:0];
                            r_ovf  <= w_ovf;
                        end
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.quot      = r_quot;
    assign bus.rem       = r_rem;
    assign bus.ovf       = r_ovf;
    assign bus.dz        = r_dz;
endmodule
`default_nettype wire

// File: tb/tb_complex_mag_stream_udiv_31ns_6ns_25_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_complex_mag_stream_udiv_31ns_6ns_25_seq
// Brief    : Directed-vector scoreboard bench for the sequential divider.
// Revision : 1.0 - initial release
// ============================================================================
module tb_complex_mag_stream_udiv_31ns_6ns_25_seq;

    typedef struct {
        logic [24:0] quot;
        logic [5:0]  rem;
        logic        ovf;
        logic        dz;
    } exp_t;

    logic ap_clk;
    logic ap_rst;
    exp_t exp_q[$];
    int   checks;
    int   errors;

    complex_mag_stream_udiv_31ns_6ns_25_seq_if bus ();

    complex_mag_stream_udiv_31ns_6ns_25_seq dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted result is compared against the queue head.
    always @(negedge ap_clk) begin
        if (!ap_rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result got quot %0d expected none", bus.quot);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("quot", bus.quot, e.quot);
                check("rem",  bus.rem,  e.rem);
                check("ovf",  bus.ovf,  e.ovf);
                check("dz",   bus.dz,   e.dz);
            end
        end
    end

    task automatic push_exp(input logic [24:0] q, input logic [5:0] r, input logic o, input logic z);
        exp_t e;
        e.quot = q;
        e.rem  = r;
        e.ovf  = o;
        e.dz   = z;
        exp_q.push_back(e);
    endtask

    task automatic start(input logic [30:0] a, input logic [5:0] b);
        int n;
        bus.in_valid = 1'b1;
        bus.din0     = a;
        bus.din1     = b;
        n = 0;
        @(negedge ap_clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge ap_clk);
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got 0 expected 1");
        end
        @(posedge ap_clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string name, input int exp_lat);
        int lat;
        lat = 1;
        @(posedge ap_clk);
        #1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge ap_clk);
            #1 lat++;
        end
        check(name, lat, exp_lat);
    endtask

    task automatic run(input logic [30:0] a, input logic [5:0] b, input logic [24:0] q,
                       input logic [5:0] r, input logic o, input logic z, input int lat);
        push_exp(q, r, o, z);
        start(a, b);
        wait_out("latency", lat);
        @(posedge ap_clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        ap_rst        = 1'b1;
        bus.in_valid  = 1'b0;
        bus.din0      = '0;
        bus.din1      = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_in_ready",  bus.in_ready,  0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quot",      bus.quot,      0);
        check("rst_rem",       bus.rem,       0);
        check("rst_ovf",       bus.ovf,       0);
        check("rst_dz",        bus.dz,        0);
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;

        run(31'd100,        6'd7,  25'd14,       6'd2,  1'b0, 1'b0, 32);
        run(31'd2113929153, 6'd63, 25'h1FFFFFF,  6'd0,  1'b0, 1'b0, 32);
        run(31'd2147483647, 6'd63, 25'h1FFFFFF,  6'd1,  1'b1, 1'b0, 32);
        run(31'd500,        6'd0,  25'h1FFFFFF,  6'd52, 1'b0, 1'b1, 1);
        run(31'd1000,       6'd1,  25'd1000,     6'd0,  1'b0, 1'b0, 32);
        run(31'd63,         6'd62, 25'd1,        6'd1,  1'b0, 1'b0, 32);

        // Back-pressure: result must hold and a new request must be refused.
        bus.out_ready = 1'b0;
        push_exp(25'd14, 6'd2, 1'b0, 1'b0);
        start(31'd100, 6'd7);
        wait_out("bp_latency", 32);
        bus.in_valid = 1'b1;
        bus.din0     = 31'd999;
        bus.din1     = 6'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready",  bus.in_ready,  0);
            check("bp_quot",      bus.quot,      14);
            check("bp_rem",       bus.rem,       2);
        end
        @(posedge ap_clk);
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        check("bp_release_in_ready",  bus.in_ready,  1);
        check("bp_release_out_valid", bus.out_valid, 0);

        // Reset mid-calculation discards the operation.
        start(31'd2147483647, 6'd5);
        repeat (14) @(posedge ap_clk);
        #1 ap_rst = 1'b1;
        @(posedge ap_clk);
        #1 ap_rst = 1'b0;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_quot",      bus.quot,      0);
        check("abort_rem",       bus.rem,       0);
        check("abort_ovf",       bus.ovf,       0);
        check("abort_dz",        bus.dz,        0);
        @(posedge ap_clk);
        #1;
        check("abort_in_ready", bus.in_ready, 1);
        run(31'd100, 6'd7, 25'd14, 6'd2, 1'b0, 1'b0, 32);

        repeat (5) @(posedge ap_clk);
        @(negedge ap_clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
